pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register that carries a PC/instruction pair between two adjacent stages of the 5-stage core (IF→ID first, reusable for later stages). Downstream stalls are absorbed by a two-entry skid buffer with valid/ready handshakes on both sides. Flush has priority over stall, and drops every held and incoming entry in one cycle. The block also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic PC/instruction pipeline register with two-entry skid buffer
// and saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [31:0]        RESET_PC  = 32'h0000_3000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_PC,
  input  logic [INSTR_W-1:0] in_instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_PC,
  output logic [INSTR_W-1:0] out_instruction,
  input  logic               flush,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [PC_W-1:0]  RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  // Encoding is {M.valid, S.valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    s_pc;
  logic [INSTR_W-1:0] s_instr;

  logic in_fire;
  logic out_fire;
  logic load_m_in;
  logic load_m_skid;
  logic load_s;
  logic bubble;
  logic stall_hit;
  logic flush_hit;

  assign in_ready        = (state != FULL);
  assign out_valid       = (state != EMPTY);
  assign out_PC          = m_pc;
  assign out_instruction = m_instr;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign stall_hit = out_valid & ~out_ready;
  assign flush_hit = flush & (state != EMPTY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    bubble      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
      bubble    = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            load_m_in = 1'b1;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_m_in = 1'b1;
          end else if (in_fire) begin
            load_s    = 1'b1;
            state_nxt = FULL;
          end else if (out_fire) begin
            bubble    = 1'b1;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            load_m_skid = 1'b1;
            state_nxt   = ONE;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // M.PC is never cleared by a bubble so debug sees where the stream stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc    <= RESET_PC_V;
      m_instr <= NOP_INSTR;
      s_pc    <= '0;
      s_instr <= NOP_INSTR;
    end else begin
      if (load_m_in) begin
        m_pc    <= in_PC;
        m_instr <= in_instruction;
      end else if (load_m_skid) begin
        m_pc    <= s_pc;
        m_instr <= s_instr;
      end else if (bubble) begin
        m_instr <= NOP_INSTR;
      end
      if (load_s) begin
        s_pc    <= in_PC;
        s_instr <= in_instruction;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush_hit && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg: FIFO reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_PC = '0;
  logic [31:0] in_instruction = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;
  logic        clr_cnt = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_PC;
  logic [31:0] out_instruction;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        sat_in_ready;
  logic        sat_out_valid;
  logic [31:0] sat_out_PC;
  logic [31:0] sat_out_instruction;
  logic [3:0]  sat_stall_cnt;
  logic [3:0]  sat_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_PC(in_PC), .in_instruction(in_instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC), .out_instruction(out_instruction),
    .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_PC(in_PC), .in_instruction(in_instruction),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_PC(sat_out_PC),
    .out_instruction(sat_out_instruction),
    .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the block is a FIFO of capacity two; the head is what is presented.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] last_pc = 32'h3000;
  int unsigned e_stall = 0;
  int unsigned e_flush = 0;
  int unsigned e_stall4 = 0;
  int unsigned e_flush4 = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      last_pc  = 32'h3000;
      e_stall  = 0;
      e_flush  = 0;
      e_stall4 = 0;
      e_flush4 = 0;
    end else begin
      int  n;
      bit  acc;
      bit  dlv;
      n   = q.size();
      acc = in_valid && (n < 2);
      dlv = (n > 0) && out_ready;
      if (clr_cnt) begin
        e_stall = 0; e_flush = 0; e_stall4 = 0; e_flush4 = 0;
      end else begin
        if (n > 0 && !out_ready) begin
          if (e_stall < 65535) e_stall++;
          if (e_stall4 < 15) e_stall4++;
        end
        if (flush && n > 0) begin
          if (e_flush < 65535) e_flush++;
          if (e_flush4 < 15) e_flush4++;
        end
      end
      if (flush) begin
        q.delete();
      end else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back('{pc: in_PC, instr: in_instruction});
      end
      if (q.size() > 0) last_pc = q[0].pc;
    end
  end

  always @(negedge clk) begin
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    if (q.size() > 0) begin
      e_pc    = q[0].pc;
      e_instr = q[0].instr;
    end else begin
      e_pc    = last_pc;
      e_instr = 32'h0;
    end
    check("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("m_out_pc", 64'(out_PC), 64'(e_pc));
    check("m_out_instr", 64'(out_instruction), 64'(e_instr));
    check("m_stall_cnt", 64'(stall_cnt), 64'(e_stall));
    check("m_flush_cnt", 64'(flush_cnt), 64'(e_flush));
    check("m_sat_stall_cnt", 64'(sat_stall_cnt), 64'(e_stall4));
    check("m_sat_flush_cnt", 64'(sat_flush_cnt), 64'(e_flush4));
  end

  task automatic step(input logic iv, input logic [31:0] pc, input logic ordy,
                      input logic fl, input logic clr);
    in_valid       = iv;
    in_PC          = pc;
    in_instruction = {16'hC0DE, pc[15:0]};
    out_ready      = ordy;
    flush          = fl;
    clr_cnt        = clr;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_pc", 64'(out_PC), 64'h3000);
    check("reset_out_instr", 64'(out_instruction), 64'h0);
    reset = 1'b1;

    // streaming at full rate
    step(1, 32'h3000, 1, 0, 0);
    check("stream_pc0", 64'(out_PC), 64'h3000);
    check("stream_rdy0", 64'(in_ready), 64'd1);
    step(1, 32'h3004, 1, 0, 0);
    check("stream_pc1", 64'(out_PC), 64'h3004);
    check("stream_rdy1", 64'(in_ready), 64'd1);
    step(1, 32'h3008, 1, 0, 0);
    check("stream_pc2", 64'(out_PC), 64'h3008);
    check("stream_instr2", 64'(out_instruction), 64'hC0DE_3008);
    step(0, 32'h0, 1, 0, 0);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_pc_kept", 64'(out_PC), 64'h3008);
    check("drain_instr_nop", 64'(out_instruction), 64'h0);

    // stall absorbed by the skid entry
    step(0, 32'h0, 1, 0, 1);
    step(1, 32'h3000, 0, 0, 0);
    check("stall_first_rdy", 64'(in_ready), 64'd1);
    step(1, 32'h3004, 0, 0, 0);
    check("stall_full_rdy", 64'(in_ready), 64'd0);
    step(1, 32'h3008, 0, 0, 0);
    step(1, 32'h3008, 0, 0, 0);
    check("stall_hold_pc", 64'(out_PC), 64'h3000);
    check("stall_cnt3", 64'(stall_cnt), 64'd3);
    step(1, 32'h3008, 1, 0, 0);
    check("release_pc1", 64'(out_PC), 64'h3004);
    check("release_rdy", 64'(in_ready), 64'd1);
    step(1, 32'h3008, 1, 0, 0);
    check("release_pc2", 64'(out_PC), 64'h3008);
    step(1, 32'h300C, 1, 0, 0);
    check("release_pc3", 64'(out_PC), 64'h300C);
    step(0, 32'h0, 1, 0, 0);
    check("release_stall_kept", 64'(stall_cnt), 64'd3);

    // flush while full with an incoming beat
    step(0, 32'h0, 1, 0, 1);
    step(1, 32'h3100, 0, 0, 0);
    step(1, 32'h3104, 0, 0, 0);
    step(1, 32'h3108, 0, 1, 0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_instr", 64'(out_instruction), 64'h0);
    check("flush_rdy", 64'(in_ready), 64'd1);
    check("flush_pc_kept", 64'(out_PC), 64'h3100);
    check("flush_cnt1", 64'(flush_cnt), 64'd1);
    check("flush_stall_cnt", 64'(stall_cnt), 64'd2);
    step(1, 32'h310C, 1, 0, 0);
    check("post_flush_pc", 64'(out_PC), 64'h310C);
    step(0, 32'h0, 1, 0, 0);

    // flush while empty, then clear racing a stall
    step(0, 32'h0, 1, 1, 0);
    check("empty_flush_cnt", 64'(flush_cnt), 64'd1);
    step(1, 32'h3200, 0, 0, 0);
    step(0, 32'h0, 0, 0, 1);
    check("clr_stall", 64'(stall_cnt), 64'd0);
    check("clr_flush", 64'(flush_cnt), 64'd0);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) step(0, 32'h0, 0, 0, 0);
    check("sat_stall15", 64'(sat_stall_cnt), 64'd15);
    check("wide_stall20", 64'(stall_cnt), 64'd20);
    step(0, 32'h0, 1, 0, 0);

    // asynchronous reset between edges
    step(1, 32'h3300, 0, 0, 0);
    step(1, 32'h3304, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("areset_valid", 64'(out_valid), 64'd0);
    check("areset_rdy", 64'(in_ready), 64'd1);
    check("areset_pc", 64'(out_PC), 64'h3000);
    check("areset_instr", 64'(out_instruction), 64'h0);
    check("areset_stall", 64'(stall_cnt), 64'd0);
    check("areset_flush", 64'(flush_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1, 32'h3400, 1, 0, 0);
    check("after_reset_pc", 64'(out_PC), 64'h3400);
    check("after_reset_valid", 64'(out_valid), 64'd1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 99) < 70,
           32'h3000 + ($urandom_range(0, 4095) << 2),
           $urandom_range(0, 99) < 65,
           $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
